// File: rtl/reg_bank.sv
// reg_bank: general-purpose register bank for the simple-viii datapath.
//
// DEPTH registers of WIDTH bits. One write port applies LOAD/INC/DEC/CLEAR to
// register wr_sel. One read port returns register rd_sel on the shared bus one
// cycle after rd_en. carry/zero report the result of the most recent write.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high; dominates wr_en/rd_en
//   in_data    write data for LOAD
//   wr_en      apply wr_op to register wr_sel this cycle
//   wr_op      00 LOAD, 01 INC, 10 DEC, 11 CLEAR
//   wr_sel     write register index
//   rd_en      request a read of register rd_sel
//   rd_sel     read register index
//   out_data   bus output, valid while out_valid=1
//   out_valid  out_data holds a read result this cycle
//   carry      carry/borrow of the last write
//   zero       last written value was zero
//
// Build option: define REG_BANK_TRISTATE_EN to drive out_data to 'z when idle
// (shared-bus mode). Otherwise idle out_data is all zeros (OR-able mux bus).

module reg_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned     SELW      = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             wr_en,
  input  logic [1:0]       wr_op,
  input  logic [SELW-1:0]  wr_sel,
  input  logic             rd_en,
  input  logic [SELW-1:0]  rd_sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [1:0] {
    OpLoad  = 2'b00,
    OpInc   = 2'b01,
    OpDec   = 2'b10,
    OpClear = 2'b11
  } wr_op_e;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             carry_q;
  logic             zero_q;

  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_new;
  logic             wr_carry;
  logic             wr_hit;
  logic [WIDTH-1:0] rd_val;

  // Index decode by loop so an out-of-range select (non-power-of-2 DEPTH)
  // matches nothing: reads return 0 and writes are dropped.
  always_comb begin
    wr_old = '0;
    rd_val = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (wr_sel == SELW'(i)) wr_old = regs_q[i];
      if (rd_sel == SELW'(i)) rd_val = regs_q[i];
    end
  end

  assign wr_hit = wr_en && (32'(wr_sel) < DEPTH);

  always_comb begin
    wr_new   = '0;
    wr_carry = 1'b0;
    unique case (wr_op_e'(wr_op))
      OpLoad: begin
        wr_new   = in_data;
        wr_carry = 1'b0;
      end
      OpInc: begin
        wr_new   = wr_old + 1'b1;
        wr_carry = &wr_old;
      end
      OpDec: begin
        wr_new   = wr_old - 1'b1;
        wr_carry = (wr_old == '0);
      end
      OpClear: begin
        wr_new   = '0;
        wr_carry = 1'b0;
      end
      default: begin
        wr_new   = '0;
        wr_carry = 1'b0;
      end
    endcase
  end

  // Read samples the pre-write contents, so a same-cycle read and write to
  // one register returns the old value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= RESET_VAL;
      end
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_val;
      end
      if (wr_hit) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (wr_sel == SELW'(i)) regs_q[i] <= wr_new;
        end
        carry_q <= wr_carry;
        zero_q  <= (wr_new == '0);
      end
    end
  end

`ifdef REG_BANK_TRISTATE_EN
  assign out_data = rd_valid_q ? rd_data_q : {WIDTH{1'bz}};
`else
  assign out_data = rd_valid_q ? rd_data_q : '0;
`endif

  assign out_valid = rd_valid_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_reg_bank.sv
// Testbench for reg_bank (WIDTH=8, DEPTH=4). A driver applies directed and
// random stimulus and pushes expected read results into a queue; a monitor on
// the falling edge pops and compares whenever out_valid is seen, and checks
// the carry/zero flags against an arithmetic model of the register file.

module tb_reg_bank;

  localparam int W = 8;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         wr_en;
  logic [1:0]   wr_op;
  logic [1:0]   wr_sel;
  logic         rd_en;
  logic [1:0]   rd_sel;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         carry;
  logic         zero;

  reg_bank #(
    .WIDTH     (W),
    .DEPTH     (D),
    .RESET_VAL ('0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .wr_en     (wr_en),
    .wr_op     (wr_op),
    .wr_sel    (wr_sel),
    .rd_en     (rd_en),
    .rd_sel    (rd_sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .carry     (carry),
    .zero      (zero)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer register values and flags.
  int model [D];
  bit m_carry = 1'b0;
  bit m_zero  = 1'b0;
  int exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus. Model is updated at the edge that samples it.
  task automatic drive(input bit rst, input bit wen, input int op, input int wsel,
                       input int din, input bit ren, input int rsel);
    int old_v;
    int new_v;
    reset   = rst;
    wr_en   = wen;
    wr_op   = 2'(op);
    wr_sel  = 2'(wsel);
    in_data = 8'(din);
    rd_en   = ren;
    rd_sel  = 2'(rsel);
    @(posedge clock);
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < D; i++) model[i] = 0;
      m_carry = 1'b0;
      m_zero  = 1'b0;
    end else begin
      if (ren) exp_q.push_back(model[rsel]);
      if (wen) begin
        old_v = model[wsel];
        case (op)
          0: begin new_v = din % 256;         m_carry = 1'b0;          end
          1: begin new_v = (old_v + 1) % 256; m_carry = (old_v == 255); end
          2: begin new_v = (old_v + 255) % 256; m_carry = (old_v == 0); end
          default: begin new_v = 0;           m_carry = 1'b0;          end
        endcase
        model[wsel] = new_v;
        m_zero = (new_v == 0);
      end
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
  endtask

  // Monitor: sample away from the rising edge.
  initial begin
    int e;
    forever begin
      @(negedge clock);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("read_data", int'(out_data), e);
        end
      end else begin
        chk("valid_low_expected", int'(exp_q.size() != 0 || out_valid !== 1'b0), 0);
        checks++;
`ifdef REG_BANK_TRISTATE_EN
        if (out_data !== {W{1'bz}}) begin
          errors++;
          $display("FAIL idle_data: got 0x%0h expected z at %0t", out_data, $time);
        end
`else
        if (out_data !== '0) begin
          errors++;
          $display("FAIL idle_data: got 0x%0h expected 0x0 at %0t", out_data, $time);
        end
`endif
      end
      chk("carry", int'(carry), int'(m_carry));
      chk("zero", int'(zero), int'(m_zero));
    end
  end

  initial begin
    for (int i = 0; i < D; i++) model[i] = 0;

    // Reset, then read every register and leave idle cycles.
    drive(1'b1, 1'b1, 0, 1, 8'h55, 1'b1, 0);
    drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 0);
    for (int i = 0; i < D; i++) drive(1'b0, 1'b0, 0, 0, 0, 1'b1, i);
    idle();
    idle();

    // LOAD then read.
    drive(1'b0, 1'b1, 0, 2, 8'hA5, 1'b0, 0);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 2);
    idle();

    // INC wrap and DEC borrow.
    drive(1'b0, 1'b1, 0, 1, 8'hFF, 1'b0, 0);
    drive(1'b0, 1'b1, 1, 1, 0, 1'b0, 0);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 1);
    drive(1'b0, 1'b1, 2, 1, 0, 1'b0, 0);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 1);
    idle();

    // Read-before-write on the same register.
    drive(1'b0, 1'b1, 0, 3, 8'h11, 1'b0, 0);
    drive(1'b0, 1'b1, 0, 3, 8'h3C, 1'b1, 3);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 3);
    idle();

    // Back-to-back reads, then idle.
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 0);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 1);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 2);
    idle();

    // Reset coinciding with a read after loads.
    drive(1'b0, 1'b1, 0, 0, 8'h7E, 1'b0, 0);
    drive(1'b0, 1'b1, 1, 0, 0, 1'b0, 0);
    drive(1'b1, 1'b1, 0, 2, 8'h99, 1'b1, 0);
    for (int i = 0; i < D; i++) drive(1'b0, 1'b0, 0, 0, 0, 1'b1, i);
    idle();

    // Randomised traffic, biased toward wrap boundaries.
    for (int n = 0; n < 400; n++) begin
      int din;
      din = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 255)
                                        : int'($urandom_range(0, 255));
      drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, D - 1)), din,
            1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)));
    end
    idle();
    idle();
    @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
